// File: rtl/heap_store_pkg.sv
// Shared types and helpers for the K-ary heap level store.
package heap_store_pkg;

  localparam int unsigned SentinelMax = 256;

  typedef enum logic [0:0] {ST_INIT, ST_READY} heap_state_e;

  // All-ones word of the requested width, right-aligned; callers truncate to DATA_WIDTH.
  function automatic logic [SentinelMax-1:0] sentinel_f(input int unsigned width);
    logic [SentinelMax-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < SentinelMax; i++) begin
      if (i < width) s[i] = 1'b1;
    end
    return s;
  endfunction

  function automatic int unsigned clog2_f(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/heap_level_store_if.sv
// Bundle of the upper-node (per-branch) and lower-node (shared) ports of one heap level.
interface heap_level_store_if
  import heap_store_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned BRANCHES   = 2
);
  localparam int unsigned SEL_W = clog2_f(BRANCHES);

  logic [BRANCHES*DATA_WIDTH-1:0]     up_din;
  logic [BRANCHES*ADDR_WIDTH-1:0]     up_addr;
  logic [BRANCHES-1:0]                up_we;
  logic [BRANCHES*DATA_WIDTH-1:0]     up_dout;
  logic [DATA_WIDTH-1:0]              dn_din;
  logic [ADDR_WIDTH-1:0]              dn_addr;
  logic                               dn_we;
  logic [SEL_W-1:0]                   dn_sel;
  logic [DATA_WIDTH-1:0]              dn_dout;
  logic                               busy;
  logic [BRANCHES*(ADDR_WIDTH+1)-1:0] occ;
  logic [BRANCHES-1:0]                collision;

  modport master (
    output up_din, up_addr, up_we, dn_din, dn_addr, dn_we, dn_sel,
    input  up_dout, dn_dout, busy, occ, collision
  );

  modport slave (
    input  up_din, up_addr, up_we, dn_din, dn_addr, dn_we, dn_sel,
    output up_dout, dn_dout, busy, occ, collision
  );
endinterface

// File: rtl/heap_branch_mem.sv
// One branch of a heap level: true-dual-port RAM, valid bits, occupancy and collision detect.
// HEAP_LEVEL_STORE_FWD_EN adds an A-write to B-read bypass on the port-B output.
module heap_branch_mem
  import heap_store_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned LEVEL      = 1
) (
  input  logic                  clk_i,
  input  logic                  clr_i,
  input  logic                  a_we_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_din_i,
  output logic [DATA_WIDTH-1:0] a_dout_o,
  input  logic                  b_we_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_din_i,
  output logic [DATA_WIDTH-1:0] b_dout_o,
  output logic [ADDR_WIDTH:0]   occ_o,
  output logic                  collision_o
);
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] Sentinel = DATA_WIDTH'(sentinel_f(DATA_WIDTH));

  logic unused_level;
  assign unused_level = ^LEVEL;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;
  logic [Depth-1:0]      valid_q, valid_d;
  logic [ADDR_WIDTH:0]   occ_q, occ_d;
  logic                  col_q, col_d;
  logic                  same_addr, b_we_eff;

  // Port A wins a same-address write/write; the port-B write is dropped.
  assign same_addr = (a_addr_i == b_addr_i);
  assign col_d     = a_we_i && b_we_i && same_addr;
  assign b_we_eff  = b_we_i && !col_d;

  always_ff @(posedge clk_i) begin
    if (b_we_eff) mem_q[b_addr_i] <= b_din_i;
    if (a_we_i)   mem_q[a_addr_i] <= a_din_i;
    a_rdata_q <= mem_q[a_addr_i];
    b_rdata_q <= mem_q[b_addr_i];
  end

  always_comb begin
    valid_d = valid_q;
    if (b_we_eff) valid_d[b_addr_i] = (b_din_i != Sentinel);
    if (a_we_i)   valid_d[a_addr_i] = (a_din_i != Sentinel);
    occ_d = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      occ_d = occ_d + (ADDR_WIDTH+1)'(valid_d[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      valid_q <= '0;
      occ_q   <= '0;
      col_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      col_q   <= col_d;
    end
  end

  assign a_dout_o    = a_rdata_q;
  assign occ_o       = occ_q;
  assign collision_o = col_q;

`ifdef HEAP_LEVEL_STORE_FWD_EN
  logic                  fwd_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;

  always_ff @(posedge clk_i) begin
    fwd_q      <= a_we_i && same_addr;
    fwd_data_q <= a_din_i;
  end

  assign b_dout_o = fwd_q ? fwd_data_q : b_rdata_q;
`else
  assign b_dout_o = b_rdata_q;
`endif

endmodule

// File: rtl/heap_level_store.sv
// One level of a K-ary hardware heap: sentinel init sweep, per-branch stores, lower-port mux.
// Optional A-to-B read bypass selected by HEAP_LEVEL_STORE_FWD_EN.
module heap_level_store
  import heap_store_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned LEVEL      = 1,
  parameter int unsigned BRANCHES   = 2
) (
  input  logic              clk,
  input  logic              rst,
  heap_level_store_if.slave bus
);
  localparam int unsigned SEL_W = clog2_f(BRANCHES);
  localparam logic [DATA_WIDTH-1:0] Sentinel = DATA_WIDTH'(sentinel_f(DATA_WIDTH));

  heap_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]      dn_sel_q;
  logic                  init_act, sweep;
  logic [DATA_WIDTH-1:0] b_dout [BRANCHES];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      dn_sel_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dn_sel_q <= bus.dn_sel;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = ST_READY;
      end
      ST_READY: ;
    endcase
  end

  always_comb begin
    init_act = rst || (state_q == ST_INIT);
    sweep    = !rst && (state_q == ST_INIT);
    bus.busy = init_act;
  end

  for (genvar i = 0; i < BRANCHES; i++) begin : g_branch
    logic                  a_we, b_we, col_w;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_din, a_dout;
    logic [ADDR_WIDTH:0]   occ_w;

    // The sweep owns port A; external writes are ignored until READY.
    always_comb begin
      if (sweep) begin
        a_we   = 1'b1;
        a_addr = cnt_q;
        a_din  = Sentinel;
      end else begin
        a_we   = bus.up_we[i] && !init_act;
        a_addr = bus.up_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        a_din  = bus.up_din[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    assign b_we = !init_act && bus.dn_we && (bus.dn_sel == SEL_W'(i));

    heap_branch_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .LEVEL      (LEVEL)
    ) u_mem (
      .clk_i       (clk),
      .clr_i       (init_act),
      .a_we_i      (a_we),
      .a_addr_i    (a_addr),
      .a_din_i     (a_din),
      .a_dout_o    (a_dout),
      .b_we_i      (b_we),
      .b_addr_i    (bus.dn_addr),
      .b_din_i     (bus.dn_din),
      .b_dout_o    (b_dout[i]),
      .occ_o       (occ_w),
      .collision_o (col_w)
    );

    assign bus.up_dout[i*DATA_WIDTH +: DATA_WIDTH]       = init_act ? '0 : a_dout;
    assign bus.occ[i*(ADDR_WIDTH+1) +: (ADDR_WIDTH+1)] = init_act ? '0 : occ_w;
    assign bus.collision[i]                              = !init_act && col_w;
  end

  // Select is delayed with the read so the mux tracks the data it belongs to.
  assign bus.dn_dout = init_act ? '0 : b_dout[dn_sel_q];

endmodule

// File: tb/tb_heap_level_store.sv
// Self-checking bench: table of single-cycle vectors plus reset / small-config sequences.
module tb_heap_level_store;
`ifdef HEAP_LEVEL_STORE_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif
  localparam logic [31:0] S  = 32'hFFFF_FFFF;
  localparam logic [63:0] S2 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  heap_level_store_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BRANCHES(2)) bus0 ();
  heap_level_store_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .BRANCHES(4)) bus1 ();

  heap_level_store #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .LEVEL(1), .BRANCHES(2)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  heap_level_store #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .LEVEL(2), .BRANCHES(4)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    logic [1:0]  up_we;
    logic [4:0]  up_addr;
    logic [31:0] up_din;
    logic        dn_we;
    logic        dn_sel;
    logic [4:0]  dn_addr;
    logic [31:0] dn_din;
    logic [31:0] exp_dn;
    logic [63:0] exp_up;
    logic [11:0] exp_occ;
    logic [1:0]  exp_col;
  } vec_t;

  typedef struct {
    bit          c0;
    logic [31:0] e0;
    bit          c1;
    logic [31:0] e1;
    string       nm;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One clock: expectation queued with the stimulus, popped once the read data is out.
  task automatic cyc(input bit c0, input logic [31:0] e0, input bit c1, input logic [31:0] e1,
                     input string nm);
    exp_t e;
    sb.push_back('{c0, e0, c1, e1, nm});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.c0) check({e.nm, " dn_dout"}, 64'(bus0.dn_dout), 64'(e.e0));
    if (e.c1) check({e.nm, " dn_dout(b4)"}, 64'(bus1.dn_dout), 64'(e.e1));
  endtask

  task automatic idle0();
    bus0.up_we = '0; bus0.up_addr = '0; bus0.up_din = '0;
    bus0.dn_we = 1'b0; bus0.dn_sel = '0; bus0.dn_addr = '0; bus0.dn_din = '0;
  endtask

  task automatic count_busy(input string nm);
    int n;
    n = 0;
    while (bus0.busy && n < 100) begin
      cyc(1'b0, '0, 1'b0, '0, "");
      n++;
    end
    check(nm, 64'(n), 64'd32);
  endtask

  task automatic add(input logic [1:0] uwe, input logic [4:0] ua, input logic [31:0] ud,
                     input logic dwe, input logic ds, input logic [4:0] da,
                     input logic [31:0] dd, input logic [31:0] edn, input logic [63:0] eup,
                     input logic [11:0] eocc, input logic [1:0] ecol);
    vq.push_back('{uwe, ua, ud, dwe, ds, da, dd, edn, eup, eocc, ecol});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // up_we  ua   up_din  dwe ds da  dn_din  exp_dn  exp_up  occ  col
    add(2'b00, 0, 0, 0, 0, 0, 0, S, S2, 12'h000, 2'b00);
    add(2'b00, 31, 0, 0, 1, 31, 0, S, S2, 12'h000, 2'b00);
    add(2'b10, 3, 32'h10, 0, 1, 0, 0, S, S2, 12'h040, 2'b00);
    add(2'b00, 3, 0, 0, 1, 3, 0, 32'h10, {32'h10, S}, 12'h040, 2'b00);
    add(2'b10, 3, S, 0, 1, 4, 0, S, {32'h10, S}, 12'h000, 2'b00);
    add(2'b00, 3, 0, 0, 1, 3, 0, S, S2, 12'h000, 2'b00);
    add(2'b01, 5, 32'hA, 1, 0, 5, 32'hB, Fwd ? 32'hA : S, S2, 12'h001, 2'b01);
    add(2'b00, 5, 0, 0, 0, 5, 0, 32'hA, {S, 32'hA}, 12'h001, 2'b00);
    add(2'b01, 10, 32'h66, 1, 0, 9, 32'h55, S, S2, 12'h003, 2'b00);
    add(2'b00, 10, 0, 0, 0, 9, 0, 32'h55, {S, 32'h66}, 12'h003, 2'b00);
    add(2'b01, 10, 32'h77, 0, 0, 5, 0, 32'hA, {S, 32'h66}, 12'h003, 2'b00);
    add(2'b00, 20, 0, 1, 1, 20, 32'h99, S, S2, 12'h043, 2'b00);
    add(2'b00, 0, 0, 0, 0, 10, 0, 32'h77, S2, 12'h043, 2'b00);
    add(2'b00, 0, 0, 0, 1, 20, 0, 32'h99, S2, 12'h043, 2'b00);
    add(2'b01, 7, 32'h22, 0, 0, 7, 0, Fwd ? 32'h22 : S, S2, 12'h044, 2'b00);
    add(2'b00, 7, 0, 0, 0, 7, 0, 32'h22, {S, 32'h22}, 12'h044, 2'b00);
    add(2'b00, 0, 0, 1, 1, 20, S, 32'h99, S2, 12'h004, 2'b00);
    add(2'b10, 6, 32'h31, 1, 1, 6, 32'h32, Fwd ? 32'h31 : S, S2, 12'h044, 2'b10);
    add(2'b00, 6, 0, 0, 1, 6, 0, 32'h31, {32'h31, S}, 12'h044, 2'b00);

    idle0();
    bus1.up_we = '0; bus1.up_addr = '0; bus1.up_din = '0;
    bus1.dn_we = 1'b0; bus1.dn_sel = '0; bus1.dn_addr = '0; bus1.dn_din = '0;

    // Power-up reset and init sweep length.
    rst = 1'b1;
    cyc(1'b0, '0, 1'b0, '0, "rst");
    check("rst busy", 64'(bus0.busy), 64'd1);
    check("rst occ", 64'(bus0.occ), 64'd0);
    check("rst dn_dout", 64'(bus0.dn_dout), 64'd0);
    check("rst up_dout", 64'(bus0.up_dout), 64'd0);
    rst = 1'b0;
    count_busy("init busy cycles");
    check("ready busy", 64'(bus0.busy), 64'd0);

    foreach (vq[k]) begin
      bus0.up_we   = vq[k].up_we;
      bus0.up_addr = {2{vq[k].up_addr}};
      bus0.up_din  = {2{vq[k].up_din}};
      bus0.dn_we   = vq[k].dn_we;
      bus0.dn_sel  = vq[k].dn_sel;
      bus0.dn_addr = vq[k].dn_addr;
      bus0.dn_din  = vq[k].dn_din;
      cyc(1'b1, vq[k].exp_dn, 1'b0, '0, $sformatf("v%0d", k));
      check($sformatf("v%0d occ", k), 64'(bus0.occ), 64'(vq[k].exp_occ));
      check($sformatf("v%0d collision", k), 64'(bus0.collision), 64'(vq[k].exp_col));
      check($sformatf("v%0d up_dout", k), bus0.up_dout, vq[k].exp_up);
    end
    idle0();

    // Reset mid-sweep at address 12, with external writes held throughout the sweep.
    rst = 1'b1;
    cyc(1'b0, '0, 1'b0, '0, "");
    rst = 1'b0;
    bus0.up_we = 2'b11; bus0.up_addr = {2{5'd2}}; bus0.up_din = {2{32'h1234}};
    repeat (12) cyc(1'b0, '0, 1'b0, '0, "");
    rst = 1'b1;
    cyc(1'b0, '0, 1'b0, '0, "");
    check("midrst busy", 64'(bus0.busy), 64'd1);
    check("midrst occ", 64'(bus0.occ), 64'd0);
    check("midrst up_dout", 64'(bus0.up_dout), 64'd0);
    check("midrst dn_dout", 64'(bus0.dn_dout), 64'd0);
    rst = 1'b0;
    bus0.dn_we = 1'b1; bus0.dn_sel = 1'b0; bus0.dn_addr = 5'd3; bus0.dn_din = 32'h4321;
    count_busy("re-init busy cycles");
    idle0();
    bus0.up_addr = {2{5'd2}};
    bus0.dn_addr = 5'd2;
    cyc(1'b1, S, 1'b0, '0, "reinit b0 a2");
    check("reinit up_dout a2", bus0.up_dout, S2);
    bus0.dn_addr = 5'd3;
    cyc(1'b1, S, 1'b0, '0, "reinit b0 a3");
    bus0.dn_addr = 5'd5;
    cyc(1'b1, S, 1'b0, '0, "reinit b0 a5");
    bus0.dn_sel = 1'b1; bus0.dn_addr = 5'd20;
    cyc(1'b1, S, 1'b0, '0, "reinit b1 a20");
    bus0.dn_addr = 5'd6;
    cyc(1'b1, S, 1'b0, '0, "reinit b1 a6");
    check("reinit occ", 64'(bus0.occ), 64'd0);
    check("reinit collision", 64'(bus0.collision), 64'd0);

    // Four-branch, depth-4 instance: fill branch 3, then alternate select on reads.
    check("b4 busy", 64'(bus1.busy), 64'd0);
    bus1.dn_we = 1'b1; bus1.dn_sel = 2'd3;
    for (int a = 0; a < 4; a++) begin
      bus1.dn_addr = 2'(a);
      bus1.dn_din  = 32'h100 + 32'(a);
      cyc(1'b0, '0, 1'b0, '0, "");
    end
    bus1.dn_we = 1'b0;
    check("b4 occ full", 64'(bus1.occ), 64'h800);
    bus1.dn_addr = 2'd1;
    for (int k = 0; k < 4; k++) begin
      bus1.dn_sel = (k % 2 == 1) ? 2'd3 : 2'd0;
      cyc(1'b0, '0, 1'b1, (k % 2 == 1) ? 32'h101 : S, $sformatf("b4 alt%0d", k));
    end
    bus1.dn_addr = 2'd3; bus1.dn_sel = 2'd3;
    cyc(1'b0, '0, 1'b1, 32'h103, "b4 b3 a3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
